// File: rtl/seradd_pkg.sv
// seradd_pkg: shared types and constants for the bit-serial adder sequencer.
//   state_t       - controller state encoding (IDLE / SHIFT / DONE)
//   DEFAULT_WIDTH - default operand/result width
package seradd_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seradd_if.sv
// seradd_if: request/response bundle between a parallel requester and seradd_ctrl.
//   in_valid/in_ready   - operation handshake (op_a, op_b, cin)
//   out_valid/out_ready - result handshake (sum, cout[, ovf])
//   busy                - sequencer is in SHIFT or DONE
// Optional: SERADD_OVF_EN adds the ovf (signed overflow) result bit.
interface seradd_if
  import seradd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERADD_OVF_EN
  logic             ovf;

  modport master (output in_valid, op_a, op_b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, busy, ovf);
  modport slave  (input  in_valid, op_a, op_b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy, ovf);
`else
  modport master (output in_valid, op_a, op_b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, busy);
  modport slave  (input  in_valid, op_a, op_b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/seradd_bit_slice.sv
// seradd_bit_slice: one-bit full adder with a registered carry.
//   clk, rst  - clock, synchronous active-high reset
//   i_load    - load carry register with i_cin
//   i_cin     - carry-in for bit 0
//   i_en      - advance carry register with the current carry-out
//   i_a, i_b  - current operand bits
//   o_sum     - sum bit for the current position
//   o_carry   - registered carry (carry into the current position)
//   o_cout    - carry out of the current position
module seradd_bit_slice (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_cin,
  input  logic i_en,
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry,
  output logic o_cout
);
  logic r_carry;

  assign o_sum   = i_a ^ i_b ^ r_carry;
  assign o_cout  = (i_a & i_b) | (i_a & r_carry) | (i_b & r_carry);
  assign o_carry = r_carry;

  always_ff @(posedge clk) begin
    if (rst)
      r_carry <= 1'b0;
    else if (i_load)
      r_carry <= i_cin;
    else if (i_en)
      r_carry <= o_cout;
  end
endmodule

// File: rtl/seradd_ctrl.sv
// seradd_ctrl: sequencer that feeds two parallel operands LSB-first through a
// serial adder slice and returns the reassembled sum with carry-out.
//   clk, rst - clock, synchronous active-high reset
//   bus      - seradd_if slave: operation in, result out, busy
// Optional: SERADD_OVF_EN adds bus.ovf (signed two's-complement overflow).
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// SHIFT | one bit added per cycle, WIDTH cycles
// DONE  | result presented, waiting for out_ready
module seradd_ctrl
  import seradd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic      clk,
  input logic      rst,
  seradd_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept, w_shift_en, w_last;
  logic             w_in_ready, w_out_valid, w_busy;
  logic             w_s, w_carry, w_cout;

  seradd_bit_slice u_slice (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_cin   (bus.cin),
    .i_en    (w_shift_en),
    .i_a     (r_a[0]),
    .i_b     (r_b[0]),
    .o_sum   (w_s),
    .o_carry (w_carry),
    .o_cout  (w_cout)
  );

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_res_next = w_s;
    end else begin : g_wn
      assign w_res_next = {w_s, r_res[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_state == SHIFT) && (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    w_shift_en  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_busy     = 1'b1;
        w_shift_en = 1'b1;
        if (r_cnt == LAST)
          w_state_nxt = DONE;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a   <= bus.op_a;
        r_b   <= bus.op_b;
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_res <= w_res_next;
        r_cnt <= r_cnt + ONE;
      end
      // Result registers only move on the final bit, so they hold the last
      // answer across IDLE and the next SHIFT.
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_cout;
      end
    end
  end

`ifdef SERADD_OVF_EN
  logic r_ovf;
  // On the final bit the registered carry is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (w_last)
      r_ovf <= w_carry ^ w_cout;
  end
  assign bus.ovf = r_ovf;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_carry;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
endmodule

// File: tb/tb_seradd_ctrl.sv
// tb_seradd_ctrl: directed-vector bench for seradd_ctrl at WIDTH=4.
module tb_seradd_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  seradd_if #(.WIDTH(W)) bus ();

  seradd_ctrl #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operation in IDLE and let exactly one edge accept it.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid, bounded.
  task automatic wait_valid(input string tag);
    int lat;
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (bus.out_valid === 1'b1) break;
      chk({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  logic [W-1:0] v_a   [4];
  logic [W-1:0] v_b   [4];
  logic         v_c   [4];
  logic [W-1:0] v_sum [4];
  logic         v_co  [4];

  initial begin
    int n_acc, n_res, last_acc, cyc;
    logic acc_now;

    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERADD_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // 5 + 3 + 0 = 8
    start(4'd5, 4'd3, 1'b0);
    wait_valid("op5p3");
    chk("op5p3_sum", 32'(bus.sum), 32'd8);
    chk("op5p3_cout", 32'(bus.cout), 32'd0);
`ifdef SERADD_OVF_EN
    chk("op5p3_ovf", 32'(bus.ovf), 32'd1);
`endif
    release_result("op5p3");
    chk("op5p3_sum_hold", 32'(bus.sum), 32'd8);

    // 15 + 1 + 0 = 16 -> 0 carry 1
    start(4'd15, 4'd1, 1'b0);
    wait_valid("op15p1");
    chk("op15p1_sum", 32'(bus.sum), 32'd0);
    chk("op15p1_cout", 32'(bus.cout), 32'd1);
`ifdef SERADD_OVF_EN
    chk("op15p1_ovf", 32'(bus.ovf), 32'd0);
`endif
    release_result("op15p1");

    // 9 + 9 + 1 = 19 -> 3 carry 1, with three cycles of backpressure
    start(4'd9, 4'd9, 1'b1);
    wait_valid("op9p9");
    for (int k = 0; k < 3; k++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      chk("bp_sum", 32'(bus.sum), 32'd3);
      chk("bp_cout", 32'(bus.cout), 32'd1);
`ifdef SERADD_OVF_EN
      chk("bp_ovf", 32'(bus.ovf), 32'd1);
`endif
      tick();
    end
    chk("bp_out_valid_end", 32'(bus.out_valid), 32'd1);
    release_result("op9p9");

    // 2 + 4 = 6 while a second request is held during SHIFT
    start(4'd2, 4'd4, 1'b0);
    bus.op_a     = 4'd15;
    bus.op_b     = 4'd15;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    wait_valid("ign");
    bus.in_valid = 1'b0;
    chk("ign_in_ready_done", 32'(bus.in_ready), 32'd0);
    chk("ign_sum", 32'(bus.sum), 32'd6);
    chk("ign_cout", 32'(bus.cout), 32'd0);
`ifdef SERADD_OVF_EN
    chk("ign_ovf", 32'(bus.ovf), 32'd0);
`endif
    release_result("ign");

    // reset during the second SHIFT cycle discards the operation
    start(4'd3, 4'd5, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_sum", 32'(bus.sum), 32'd0);
    chk("mrst_cout", 32'(bus.cout), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mrst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    start(4'd7, 4'd7, 1'b0);
    wait_valid("op7p7");
    chk("op7p7_sum", 32'(bus.sum), 32'd14);
    chk("op7p7_cout", 32'(bus.cout), 32'd0);
`ifdef SERADD_OVF_EN
    chk("op7p7_ovf", 32'(bus.ovf), 32'd1);
`endif
    release_result("op7p7");

    // back-to-back with in_valid high and out_ready tied high
    v_a[0] = 4'd1;  v_b[0] = 4'd2;  v_c[0] = 1'b0; v_sum[0] = 4'd3;  v_co[0] = 1'b0;
    v_a[1] = 4'd8;  v_b[1] = 4'd8;  v_c[1] = 1'b0; v_sum[1] = 4'd0;  v_co[1] = 1'b1;
    v_a[2] = 4'd6;  v_b[2] = 4'd9;  v_c[2] = 1'b1; v_sum[2] = 4'd0;  v_co[2] = 1'b1;
    v_a[3] = 4'd10; v_b[3] = 4'd3;  v_c[3] = 1'b1; v_sum[3] = 4'd14; v_co[3] = 1'b0;
    n_acc    = 0;
    n_res    = 0;
    last_acc = 0;
    cyc      = 0;
    bus.op_a      = v_a[0];
    bus.op_b      = v_b[0];
    bus.cin       = v_c[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (n_res < 4 && cyc < 60) begin
      if (bus.out_valid === 1'b1) begin
        chk("b2b_sum", 32'(bus.sum), 32'(v_sum[n_res]));
        chk("b2b_cout", 32'(bus.cout), 32'(v_co[n_res]));
        n_res++;
      end
      acc_now = (bus.in_ready === 1'b1) && bus.in_valid;
      tick();
      cyc++;
      if (acc_now) begin
        if (n_acc > 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
        n_acc++;
        if (n_acc < 4) begin
          bus.op_a = v_a[n_acc];
          bus.op_b = v_b[n_acc];
          bus.cin  = v_c[n_acc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("b2b_results", 32'(n_res), 32'd4);
    chk("b2b_accepts", 32'(n_acc), 32'd4);
    bus.out_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seradd_ctrl.md
Name: seradd_ctrl

Overview:
Sequencer for a bit-serial adder datapath. Accepts two parallel WIDTH-bit operands plus carry-in over a valid/ready handshake and streams them LSB-first through a one-bit full-adder slice with a registered carry. Reassembles the sum and returns it with carry-out over a second valid/ready handshake. Sits between a parallel requester (ALU/test controller) and the serial add datapath, replacing free-running serial adders that have no start/done control.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  requester presents op_a/op_b/cin
in_ready  output  1  block can accept an operation
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
cin  input  1  carry-in for bit 0
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  op_a+op_b+cin, low WIDTH bits
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE; in_ready=1, out_valid=0, busy=0, sum=0, cout=0; shift regs, carry, bit counter cleared. Overrides everything, including mid-operation (operation discarded, no out_valid).
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge E0: load A_sh<=op_a, B_sh<=op_b, carry<=cin, cnt<=0, go SHIFT. in_valid with in_ready=0 is ignored (not queued).
- SHIFT: one bit per cycle: s=A_sh[0]^B_sh[0]^carry; carry<=majority(A_sh[0],B_sh[0],carry); res<={s,res[WIDTH-1:1]}; A_sh,B_sh shift right; cnt<=cnt+1. At the edge where cnt==WIDTH-1 (edge E_WIDTH): go DONE, sum<=final res, cout<=final carry.
- DONE: out_valid=1, sum/cout held stable until out_ready=1 at an edge, then go IDLE. out_valid never drops without out_ready.
- Latency: out_valid high WIDTH cycles after accept edge E0. Minimum throughput: one op per WIDTH+2 cycles (in_ready only in IDLE; no overlap of DONE with new accept).
- cnt width $clog2(WIDTH+1); WIDTH=1 takes a single SHIFT cycle.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry.
- sum/cout outside DONE: hold last result (reset value 0). Consumers qualify with out_valid.

Optional Feature:
SERADD_OVF_EN: when defined, adds output port ovf (1 bit) = carry into MSB XOR carry out of MSB (signed two's-complement overflow), registered with sum and valid under out_valid; reset 0. When undefined, port and logic absent; all other behaviour identical.

Decomposition:
- Package seradd_pkg: state enum type (IDLE/SHIFT/DONE encoding), default WIDTH constant.
- One sub-module: seradd_bit_slice: full adder plus carry register with synchronous load (carry<=cin on load) and enable (carry update in SHIFT). Controller owns FSM, shift registers, counter, handshakes.

Test Plan:
- WIDTH=4: op_a=5, op_b=3, cin=0 -> out_valid 4 cycles after accept, sum=8, cout=0 (with SERADD_OVF_EN: ovf=1).
- op_a=15, op_b=1, cin=0 -> sum=0, cout=1; op_a=9, op_b=9, cin=1 -> sum=3, cout=1.
- Backpressure: out_ready held 0 for 3 cycles after out_valid -> sum/cout/out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- in_valid with new operands during SHIFT -> ignored; result matches first operation only; in_ready=0 throughout busy.
- rst=1 at 2nd SHIFT cycle -> next cycle IDLE, out_valid=0, sum=0, cout=0; following op 7+7 cin=0 -> sum=14, cout=0.
- Back-to-back: in_valid held high, out_ready tied 1 -> accepts spaced exactly WIDTH+2 cycles apart, each result correct.
